// File: rtl/fifo_pkt_framer_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkt_framer_pkg
// Shared types and default constants for the FIFO packet framer and anything
// that needs to agree with it (scoreboards, coverage, integration wrappers).
//   pkt_state_e    : framer FSM states
//   DEF_FIFO_WIDTH : default data width of the attached FIFO
//   DEF_PKT_LEN    : default payload words per packet
//   DEF_HDR_TAG    : default upper byte of every header word
// ---------------------------------------------------------------------------
package fifo_pkt_framer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAYLOAD,
        CSUM
    } pkt_state_e;

    localparam int unsigned DEF_FIFO_WIDTH = 16;
    localparam int unsigned DEF_PKT_LEN    = 4;
    localparam logic [7:0]  DEF_HDR_TAG    = 8'hA5;

endpackage

// File: rtl/fifo_pkt_framer.sv
// ---------------------------------------------------------------------------
// fifo_pkt_framer
// Read-side consumer of a synchronous FIFO. Drains FIFO words and frames them
// into fixed-length packets for a valid/ready sink:
//   header {HDR_TAG, seq}, PKT_LEN payload words, XOR checksum (out_last=1).
// A single FIFO read is outstanding at a time, the FIFO is never read while
// empty and no word is dropped or reordered under backpressure.
//
// Ports
//   clk           : clock, rising edge
//   rst_n         : asynchronous active-low reset
//   fifo_empty    : FIFO empty flag
//   fifo_data_out : FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en    : FIFO read request (combinational)
//   out_data      : framed output word
//   out_valid     : out_data valid
//   out_last      : marks the checksum word
//   out_ready     : sink accepts when out_valid && out_ready at a rising edge
// ---------------------------------------------------------------------------
module fifo_pkt_framer
    import fifo_pkt_framer_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int unsigned PKT_LEN    = DEF_PKT_LEN,
    parameter logic [7:0]  HDR_TAG    = DEF_HDR_TAG
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic [FIFO_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready
);

    localparam int unsigned    CW       = $clog2(PKT_LEN + 1);
    localparam logic [CW-1:0]  LAST_IDX = CW'(PKT_LEN - 1);
    localparam logic [CW-1:0]  REQ_MAX  = CW'(PKT_LEN);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    pkt_state_e            state;
    logic [7:0]            seq;
    logic [FIFO_WIDTH-1:0] csum;
    logic [FIFO_WIDTH-1:0] buf_data;
    logic                  buf_v;
    logic                  pend;
    logic [CW-1:0]         word_cnt;
    logic [CW-1:0]         words_req;
    logic [FIFO_WIDTH-1:0] hdr_word;
    logic                  handshake;

    assign hdr_word  = FIFO_WIDTH'({HDR_TAG, seq});
    assign handshake = out_valid && out_ready;

    // One read in flight at most: blocked while a read is pending, while the
    // buffered word is still unsent, and once the packet's quota is requested.
    assign fifo_rd_en = (state == PAYLOAD) && !fifo_empty && !pend && !buf_v
                        && (words_req < REQ_MAX);

    // Outputs are registered: each transition loads the value the next state
    // presents, so out_data/out_valid/out_last match the state's definition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            seq       <= '0;
            csum      <= '0;
            buf_data  <= '0;
            buf_v     <= 1'b0;
            pend      <= 1'b0;
            word_cnt  <= '0;
            words_req <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            pend <= fifo_rd_en;
            if (fifo_rd_en) begin
                words_req <= words_req + CNT_ONE;
            end

            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state     <= HDR;
                        out_data  <= hdr_word;
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                    end
                end

                HDR: begin
                    if (handshake) begin
                        seq       <= seq + 8'd1;
                        csum      <= '0;
                        word_cnt  <= '0;
                        words_req <= '0;
                        out_valid <= 1'b0;
                        state     <= PAYLOAD;
                    end
                end

                PAYLOAD: begin
                    // pend implies !buf_v, so capture and acceptance never
                    // coincide.
                    if (pend) begin
                        buf_data  <= fifo_data_out;
                        buf_v     <= 1'b1;
                        out_data  <= fifo_data_out;
                        out_valid <= 1'b1;
                    end
                    if (handshake) begin
                        csum     <= csum ^ buf_data;
                        buf_v    <= 1'b0;
                        word_cnt <= word_cnt + CNT_ONE;
                        if (word_cnt == LAST_IDX) begin
                            state     <= CSUM;
                            out_data  <= csum ^ buf_data;
                            out_valid <= 1'b1;
                            out_last  <= 1'b1;
                        end else begin
                            out_valid <= 1'b0;
                        end
                    end
                end

                CSUM: begin
                    if (handshake) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_pkt_framer.sv
// ---------------------------------------------------------------------------
// tb_fifo_pkt_framer
// Self-checking bench for fifo_pkt_framer. A queue-based FIFO model feeds the
// DUT; expected output words are built from the packet format (header with
// running sequence number, payload, XOR checksum) and compared on every
// accepted word.
// ---------------------------------------------------------------------------
module tb_fifo_pkt_framer;
    import fifo_pkt_framer_pkg::*;

    localparam int unsigned W  = DEF_FIFO_WIDTH;
    localparam int unsigned PL = DEF_PKT_LEN;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         fifo_empty = 1'b1;
    logic [W-1:0] fifo_data_out = '0;
    logic         fifo_rd_en;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_last;
    logic         out_ready = 1'b0;

    always #5 clk = ~clk;

    fifo_pkt_framer #(
        .FIFO_WIDTH (W),
        .PKT_LEN    (PL),
        .HDR_TAG    (DEF_HDR_TAG)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fifo_empty    (fifo_empty),
        .fifo_data_out (fifo_data_out),
        .fifo_rd_en    (fifo_rd_en),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_last      (out_last),
        .out_ready     (out_ready)
    );

    typedef struct {
        logic [W-1:0] d;
        logic         l;
    } exp_t;

    typedef struct {
        logic [PL-1:0][W-1:0] w;
        int unsigned          mode;
        logic [W-1:0]         csum;
    } vec_t;

    exp_t         exp_q[$];
    logic [W-1:0] fq[$];
    logic [W-1:0] pay_q[$];
    logic [W-1:0] src_q[$];
    vec_t         vecs[5];

    int           checks = 0;
    int           errors = 0;
    int           rd_cnt = 0;
    int           hs_cnt = 0;
    int unsigned  ready_mode = 0;
    bit           idle_chk = 1'b0;
    logic [7:0]   seq_m = '0;
    bit           pv = 1'b0;
    bit           pr = 1'b0;
    bit           pl = 1'b0;
    logic [W-1:0] pd = '0;

    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] c, input logic [W-1:0] d,
                                input int unsigned m, input logic [W-1:0] cs);
        vec_t v;
        v.w[0] = a; v.w[1] = b; v.w[2] = c; v.w[3] = d;
        v.mode = m;
        v.csum = cs;
        return v;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model: payload words accumulate; every PL words form a packet.
    task automatic expect_word(input logic [W-1:0] w);
        logic [W-1:0] x;
        exp_t e;
        pay_q.push_back(w);
        if (pay_q.size() == PL) begin
            e.d = W'({DEF_HDR_TAG, seq_m}); e.l = 1'b0; exp_q.push_back(e);
            x = '0;
            for (int unsigned k = 0; k < PL; k++) begin
                e.d = pay_q.pop_front(); e.l = 1'b0;
                x = x ^ e.d;
                exp_q.push_back(e);
            end
            e.d = x; e.l = 1'b1; exp_q.push_back(e);
            seq_m = seq_m + 8'd1;
        end
    endtask

    // Table vectors carry their checksum as a hand-computed constant.
    task automatic expect_fixed(input vec_t v);
        exp_t e;
        e.d = W'({DEF_HDR_TAG, seq_m}); e.l = 1'b0; exp_q.push_back(e);
        for (int unsigned k = 0; k < PL; k++) begin
            e.d = v.w[k]; e.l = 1'b0; exp_q.push_back(e);
        end
        e.d = v.csum; e.l = 1'b1; exp_q.push_back(e);
        seq_m = seq_m + 8'd1;
    endtask

    task automatic push(input logic [W-1:0] w);
        fq.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // One clock: observe at the negedge, then update the FIFO model and the
    // sink's ready just after the rising edge.
    task automatic cycle();
        bit rd_s;
        exp_t e;
        @(negedge clk);
        rd_s = fifo_rd_en;
        if (rd_s) begin
            rd_cnt++;
            chk("no_underflow", W'(fifo_empty), '0);
        end
        if (pv && !pr) begin
            chk("hold_valid", W'(out_valid), W'(1));
            chk("hold_data", out_data, pd);
            chk("hold_last", W'(out_last), W'(pl));
        end
        if (idle_chk) begin
            chk("quiet_valid", W'(out_valid), '0);
            chk("quiet_rd_en", W'(fifo_rd_en), '0);
        end
        if (out_valid && out_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %h expected none at %0t", out_data, $time);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", out_data, e.d);
                chk("out_last", W'(out_last), W'(e.l));
            end
        end
        pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
        @(posedge clk);
        #1;
        if (rd_s && fq.size() != 0) fifo_data_out = fq.pop_front();
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        fifo_empty = (fq.size() == 0);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d words outstanding expected 0", name, exp_q.size());
        end
        repeat (3) cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_out_data", out_data, '0);
        chk("rst_out_valid", W'(out_valid), '0);
        chk("rst_out_last", W'(out_last), '0);
        chk("rst_rd_en", W'(fifo_rd_en), '0);
        exp_q.delete();
        pay_q.delete();
        seq_m = '0;
        pv = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int base;
        int r;

        vecs[0] = mk(16'h0001, 16'h0002, 16'h0003, 16'h0004, 0, 16'h0004);
        vecs[1] = mk(16'h00F0, 16'h000F, 16'hFF00, 16'h1234, 1, 16'hEDCB);
        vecs[2] = mk(16'hFFFF, 16'h0000, 16'hAAAA, 16'h5555, 2, 16'h0000);
        vecs[3] = mk(16'h0001, 16'h0002, 16'h0004, 16'h0008, 1, 16'h000F);
        vecs[4] = mk(16'hDEAD, 16'hBEEF, 16'h0000, 16'h0000, 0, 16'h6042);

        #2;
        do_reset();

        // Table vectors: basic frame, backpressure and assorted checksums.
        foreach (vecs[i]) begin
            ready_mode = vecs[i].mode;
            rd_cnt = 0;
            expect_fixed(vecs[i]);
            for (int unsigned k = 0; k < PL; k++) push(vecs[i].w[k]);
            drain("vector_drain", 300);
            chk("rd_pulses", W'(rd_cnt), W'(PL));
        end

        // Starvation: half a packet, a long gap, then the rest.
        ready_mode = 0;
        for (int unsigned k = 0; k < PL; k++) src_q.push_back(W'($urandom));
        foreach (src_q[k]) expect_word(src_q[k]);
        push(src_q.pop_front());
        push(src_q.pop_front());
        repeat (30) cycle();
        idle_chk = 1'b1;
        repeat (20) cycle();
        idle_chk = 1'b0;
        while (src_q.size() != 0) push(src_q.pop_front());
        drain("starve_drain", 300);

        // Idle: empty FIFO for 100 cycles.
        idle_chk = 1'b1;
        repeat (100) cycle();
        idle_chk = 1'b0;

        // Random payloads, random ready, random push timing.
        ready_mode = 2;
        for (int unsigned k = 0; k < 10 * PL; k++) src_q.push_back(W'($urandom));
        foreach (src_q[k]) expect_word(src_q[k]);
        n = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && n < 3000) begin
            cycle();
            if (src_q.size() != 0 && $urandom_range(0, 2) != 0) push(src_q.pop_front());
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_drain: got %0d words outstanding expected 0", exp_q.size());
        end
        repeat (3) cycle();

        // Sequence wrap: 257 all-zero packets from a fresh reset.
        do_reset();
        ready_mode = 0;
        for (int unsigned p = 0; p < 257 * PL; p++) begin
            expect_word('0);
            push('0);
        end
        drain("wrap_drain", 6000);

        // Reset after the second payload word of a packet is accepted.
        do_reset();
        ready_mode = 0;
        for (int unsigned k = 1; k <= PL + 2; k++) begin
            expect_word(W'(16'h0100 + k));
            push(W'(16'h0100 + k));
        end
        base = hs_cnt;
        n = 0;
        while (hs_cnt < base + 3 && n < 100) begin
            cycle();
            n++;
        end
        chk("mid_pkt_reach", W'(hs_cnt - base), W'(3));
        do_reset();
        r = fq.size();
        foreach (fq[k]) expect_word(fq[k]);
        for (int k = r; k < int'(PL); k++) begin
            expect_word(W'(16'h0200 + k));
            push(W'(16'h0200 + k));
        end
        drain("reset_drain", 300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
